iru_rot_engine: RTL and testbench



---
 rtl/iru_rot_engine.sv | 171 +++++++++++++++++
 tb/tb_iru_rot_engine.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/iru_rot_engine.sv
// Image rotation engine: loads a square frame, then streams it rotated about its centre
// using inverse-mapped nearest-neighbour sampling from a sin/cos LUT.
module iru_rot_engine #(
  parameter int IMG_DIM  = 20,
  parameter int LANES    = 5,
  parameter int PIX_W    = 8,
  parameter int N_ANGLES = 36,
  parameter int ANGLE_W  = 6,
  parameter int COEF_W   = 10,
  parameter int FILL     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*PIX_W-1:0]   in_data,
  input  logic [ANGLE_W-1:0]       in_angle,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*PIX_W-1:0]   out_data,
  output logic                     out_last,
  output logic                     busy
);
  localparam int NPIX   = IMG_DIM * IMG_DIM;
  localparam int B      = NPIX / LANES;
  localparam int BEAT_W = (B > 1) ? $clog2(B) : 1;
  localparam int AW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int XW     = $clog2(IMG_DIM + LANES) + 1;
  localparam int F      = COEF_W - 2;
  localparam int CW     = COEF_W + $clog2(2 * IMG_DIM) + 2;
  localparam real PI    = 3.14159265358979323846;
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(B - 1);
  localparam logic signed [CW-1:0] OFF     = CW'(IMG_DIM * (2 ** F));
  localparam logic signed [CW-1:0] MAXC    = CW'(IMG_DIM - 1);

  function automatic int lut_coef(input int k, input bit want_cos);
    real ang, t;
    ang = 2.0 * PI * real'(k) / real'(N_ANGLES);
    t   = (want_cos ? $cos(ang) : $sin(ang)) * real'(2 ** F);
    return (t >= 0.0) ? $rtoi(t + 0.5) : -$rtoi(0.5 - t);
  endfunction

  typedef enum logic [1:0] {LOAD, ROTATE, STREAM} state_t;
  state_t state_reg, state_next;

  logic [BEAT_W-1:0]      in_cnt_reg, fc_reg;
  logic [ANGLE_W-1:0]     angle_reg;
  logic [XW-1:0]          fx_reg, fy_reg, x_sum;
  logic                   in_fire, fetch;
  logic [AW-1:0]          wbase;
  logic [LANES*PIX_W-1:0] fetch_data;
  logic [N_ANGLES*COEF_W-1:0] cos_tab, sin_tab;
  logic signed [COEF_W-1:0]   c_sel, s_sel;
  logic signed [CW-1:0]       c_ext, s_ext;
  logic [PIX_W-1:0]       mem [NPIX];

  genvar gi;
  for (gi = 0; gi < N_ANGLES; gi++) begin : g_lut
    localparam int CV = lut_coef(gi, 1'b1);
    localparam int SV = lut_coef(gi, 1'b0);
    assign cos_tab[gi*COEF_W +: COEF_W] = CV[COEF_W-1:0];
    assign sin_tab[gi*COEF_W +: COEF_W] = SV[COEF_W-1:0];
  end

  assign c_sel = cos_tab[angle_reg*COEF_W +: COEF_W];
  assign s_sel = sin_tab[angle_reg*COEF_W +: COEF_W];
  assign c_ext = {{(CW-COEF_W){c_sel[COEF_W-1]}}, c_sel};
  assign s_ext = {{(CW-COEF_W){s_sel[COEF_W-1]}}, s_sel};

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    fetch      = 1'b0;
    case (state_reg)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && in_cnt_reg == LAST_BEAT) state_next = ROTATE;
      end
      ROTATE: begin
        fetch      = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        fetch = out_valid && out_ready && !out_last;
        if (out_valid && out_ready && out_last) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  assign in_fire = in_valid && in_ready;
  assign wbase   = AW'(in_cnt_reg) * AW'(LANES);
  assign x_sum   = fx_reg + XW'(LANES);

  always_ff @(posedge clk) begin
    if (in_fire)
      for (int i = 0; i < LANES; i++)
        mem[wbase + AW'(i)] <= in_data[i*PIX_W +: PIX_W];
  end

  // Each lane maps its output pixel back to a source pixel in doubled, centred coordinates.
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic [XW-1:0]        lx, ly;
    logic signed [CW-1:0] dx, dy, u, v, sx, sy;
    logic                 in_range;
    logic [AW-1:0]        addr;
    logic [PIX_W-1:0]     pix;
    always_comb begin
      lx = fx_reg + XW'(gi);
      ly = fy_reg;
      if (lx >= XW'(IMG_DIM)) begin
        lx = lx - XW'(IMG_DIM);
        ly = fy_reg + 1'b1;
      end
      dx = $signed({{(CW-XW-1){1'b0}}, lx, 1'b0}) - MAXC;
      dy = $signed({{(CW-XW-1){1'b0}}, ly, 1'b0}) - MAXC;
      u  = c_ext * dx + s_ext * dy;
      v  = c_ext * dy - s_ext * dx;
      sx = (u + OFF) >>> (F + 1);
      sy = (v + OFF) >>> (F + 1);
      in_range = (sx >= 0) && (sx <= MAXC) && (sy >= 0) && (sy <= MAXC);
      addr = '0;
      if (in_range) addr = AW'(sy) * AW'(IMG_DIM) + AW'(sx);
      pix = in_range ? mem[addr] : PIX_W'(FILL);
    end
    assign fetch_data[gi*PIX_W +: PIX_W] = pix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= LOAD;
      in_cnt_reg <= '0;
      angle_reg  <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      fc_reg     <= '0;
      fx_reg     <= '0;
      fy_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (in_fire) begin
        in_cnt_reg <= (in_cnt_reg == LAST_BEAT) ? '0 : in_cnt_reg + 1'b1;
        if (in_cnt_reg == '0) begin
          angle_reg <= (int'(in_angle) >= N_ANGLES) ? '0 : in_angle;
          busy      <= 1'b1;
        end
      end
      if (fetch) begin
        out_data  <= fetch_data;
        out_valid <= 1'b1;
        out_last  <= (fc_reg == LAST_BEAT);
        fc_reg    <= fc_reg + 1'b1;
        if (x_sum >= XW'(IMG_DIM)) begin
          fx_reg <= x_sum - XW'(IMG_DIM);
          fy_reg <= fy_reg + 1'b1;
        end else begin
          fx_reg <= x_sum;
        end
      end else if (out_valid && out_ready && out_last) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
        fc_reg    <= '0;
        fx_reg    <= '0;
        fy_reg    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_iru_rot_engine.sv
// Randomised bench for iru_rot_engine: frames are loaded, rotated output is compared
// against a direct per-pixel rotation model, plus latency/handshake/reset checks.
module tb_iru_rot_engine;
  localparam int IMG = 20, LANES = 5, PIX_W = 8, NA = 36, B = 80, F = 8;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last, busy;
  logic [LANES*PIX_W-1:0] in_data = '0, out_data;
  logic [5:0] in_angle = '0;

  int frame [IMG*IMG];
  int expv  [IMG*IMG];
  int got   [IMG*IMG];
  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  iru_rot_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_angle(in_angle), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int coef(input int k, input bit want_cos);
    real a, t;
    a = 2.0 * PI * real'(k) / real'(NA);
    t = (want_cos ? $cos(a) : $sin(a)) * 256.0;
    return (t >= 0.0) ? $rtoi(t + 0.5) : -$rtoi(0.5 - t);
  endfunction

  // Reference: rotate every output pixel back into the source frame.
  task automatic model(input int ang);
    int k, c, s, dx, dy, sx, sy;
    k = (ang >= NA) ? 0 : ang;
    c = coef(k, 1'b1);
    s = coef(k, 1'b0);
    for (int y = 0; y < IMG; y++)
      for (int x = 0; x < IMG; x++) begin
        dx = 2 * x - (IMG - 1);
        dy = 2 * y - (IMG - 1);
        sx = (c * dx + s * dy + IMG * 256) >>> (F + 1);
        sy = (c * dy - s * dx + IMG * 256) >>> (F + 1);
        if (sx >= 0 && sx < IMG && sy >= 0 && sy < IMG) expv[y*IMG+x] = frame[sy*IMG+sx];
        else expv[y*IMG+x] = 0;
      end
  endtask

  task automatic fill_frame(input int kind);
    for (int y = 0; y < IMG; y++)
      for (int x = 0; x < IMG; x++)
        case (kind)
          0: frame[y*IMG+x] = (x + 7 * y) & 8'hFF;
          1: frame[y*IMG+x] = 8'hAA;
          default: frame[y*IMG+x] = int'($urandom_range(0, 255));
        endcase
  endtask

  task automatic load_frame(input int ang);
    int lat;
    for (int b = 0; b < B; b++) begin
      if (b != 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_angle = (b == 0) ? 6'(ang) : 6'($urandom);
      for (int i = 0; i < LANES; i++) in_data[i*PIX_W +: PIX_W] = 8'(frame[b*LANES+i]);
      if (b == 0) chk("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
      if (b == 0) chk("busy_first_beat", busy, 1);
    end
    in_valid = 1'b0;
    chk("in_ready_rotate", in_ready, 0);
    chk("out_valid_rotate", out_valid, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("first_valid_latency", lat, 1);
  endtask

  task automatic collect(input bit rand_ready, input int abort_at, output int hs);
    int cyc;
    bit stalled;
    logic [LANES*PIX_W-1:0] held, expb;
    hs = 0; cyc = 0; stalled = 0; held = '0;
    while (hs < B && hs < abort_at && cyc < 2000) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled && out_valid) chk("stall_hold", out_data, held);
      if (out_valid && out_ready) begin
        for (int i = 0; i < LANES; i++) begin
          expb[i*PIX_W +: PIX_W] = 8'(expv[hs*LANES+i]);
          got[hs*LANES+i] = int'(out_data[i*PIX_W +: PIX_W]);
        end
        chk("beat_data", out_data, expb);
        chk("beat_last", out_last, (hs == B - 1));
        hs++;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        held = out_data;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 2000) chk("stream_timeout", hs, B);
    out_ready = 1'b1;
    if (hs == B) begin
      chk("out_valid_after_last", out_valid, 0);
      chk("busy_after_last", busy, 0);
      chk("in_ready_after_last", in_ready, 1);
    end
  endtask

  task automatic run_frame(input int kind, input int ang, input bit rand_ready, input int abort_at);
    int hs;
    fill_frame(kind);
    model(ang);
    load_frame(ang);
    collect(rand_ready, abort_at, hs);
    $display("frame kind=%0d angle=%0d rand_ready=%0d beats=%0d checks=%0d passed=%0d",
             kind, ang, rand_ready, hs, n_checks, n_pass);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(0, 0, 1'b0, B);
    run_frame(0, 9, 1'b0, B);
    chk("rot90_out00", got[0], 133);
    chk("rot90_out190", got[19], 0);
    run_frame(0, 18, 1'b0, B);
    chk("rot180_out00", got[0], 152);
    run_frame(0, 40, 1'b0, B);
    chk("invalid_angle_identity", got[123], (3 + 7 * 6) & 8'hFF);
    run_frame(1, 4, 1'b0, B);
    chk("rot40_corner00", got[0], 0);
    chk("rot40_corner190", got[19], 0);
    chk("rot40_corner019", got[380], 0);
    chk("rot40_corner1919", got[399], 0);
    chk("rot40_centre99", got[9*IMG+9], 8'hAA);
    chk("rot40_centre1010", got[10*IMG+10], 8'hAA);
    run_frame(0, 9, 1'b1, B);
    run_frame(2, int'($urandom_range(0, NA - 1)), 1'b1, B);

    run_frame(0, 9, 1'b0, 30);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_idle_valid", out_valid, 0);
    run_frame(0, 0, 1'b0, B);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
